udp_rx_bank_ctrl: RTL

Ping-pong frame buffer controller placed behind the GMII UDP receiver. It claims one of two RAM banks per incoming UDP frame, steers the receiver's 32-bit word stream into that bank, and commits the frame when it ends. Committed frames are presented to a downstream consumer (DSP/config logic) in arrival order. Frames are dropped when no bank is free, when a frame overflows its bank, or, optionally, when the destination port does not match.

---
 rtl/udp_rx_bank_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/udp_rx_bank_ctrl.sv
// udp_rx_bank_ctrl: ping-pong frame buffer controller behind the UDP receiver.
// Claims one of two RAM banks per frame, steers payload words into it and
// presents committed frames to the consumer in arrival order.
// Optional build macro: UDP_RX_PORT_FILTER_EN (drop frames whose UDP
// destination port differs from RX_PORT, without counting them).
module udp_rx_bank_ctrl #(
    parameter int          ADDR_W  = 9,
    parameter logic [15:0] RX_PORT = 16'h1F90
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              frame_start,
    input  logic [63:0]       udp_hdr,
    input  logic              wr_valid,
    input  logic [31:0]       wr_data,
    input  logic              frame_done,
    output logic              ram_we,
    output logic [ADDR_W:0]   ram_waddr,
    output logic [31:0]       ram_wdata,
    output logic              rd_valid,
    output logic              rd_bank,
    output logic [ADDR_W:0]   rd_words,
    input  logic              rd_done,
    output logic [15:0]       drop_cnt
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {B_FREE, B_FILL, B_FULL} bank_st_t;
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;

    bank_st_t          bank_st [2];
    logic [ADDR_W:0]   len [2];
    logic              older;      // FULL bank committed first
    logic              last;       // bank claimed most recently
    logic              cur;        // bank being filled
    wstate_t           wstate;
    logic [ADDR_W:0]   wcnt;

    logic              full0, full1, free0, free1;
    logic              port_ok, claim_ok, claim_bank;
    logic [ADDR_W:0]   commit_len;

    // Header is only partly consulted, and only with filtering built in.
    logic unused_hdr;
    assign unused_hdr = ^udp_hdr;

    // Port filter decision for a new frame
    always_comb begin
`ifdef UDP_RX_PORT_FILTER_EN
        port_ok = (udp_hdr[47:32] == RX_PORT);
`else
        port_ok = 1'b1;
`endif
    end

    // Bank status, claim choice and read-side presentation, all from registered state
    always_comb begin
        full0      = (bank_st[0] == B_FULL);
        full1      = (bank_st[1] == B_FULL);
        free0      = (bank_st[0] == B_FREE);
        free1      = (bank_st[1] == B_FREE);
        claim_ok   = free0 | free1;
        claim_bank = (free0 && free1) ? ~last : ~free0;
        commit_len = wcnt + {{ADDR_W{1'b0}}, wr_valid};
        rd_valid   = full0 | full1;
        rd_bank    = (full0 && full1) ? older : full1;
        rd_words   = rd_valid ? len[rd_bank] : '0;
    end

    // Write FSM, bank bookkeeping, registered RAM port and drop counter
    always_ff @(posedge clk) begin
        if (clr) begin
            bank_st[0] <= B_FREE;
            bank_st[1] <= B_FREE;
            len[0]     <= '0;
            len[1]     <= '0;
            older      <= 1'b0;
            last       <= 1'b1;
            cur        <= 1'b0;
            wstate     <= W_IDLE;
            wcnt       <= '0;
            ram_we     <= 1'b0;
            ram_waddr  <= '0;
            ram_wdata  <= '0;
            drop_cnt   <= '0;
        end else begin
            ram_we <= 1'b0;

            // Consumer release; rd_bank is always a FULL bank, never the one filling
            if (rd_done && rd_valid)
                bank_st[rd_bank] <= B_FREE;

            if (frame_start) begin
                // A new header aborts whatever frame was in progress
                if (wstate == W_FILL)
                    bank_st[cur] <= B_FREE;
                if (!port_ok) begin
                    wstate <= W_DROP;
                end else if (claim_ok) begin
                    bank_st[claim_bank] <= B_FILL;
                    cur    <= claim_bank;
                    last   <= claim_bank;
                    wcnt   <= '0;
                    wstate <= W_FILL;
                end else begin
                    wstate <= W_DROP;
                    if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                end
            end else begin
                case (wstate)
                    W_FILL: begin
                        if (wr_valid && wcnt == DEPTH) begin
                            // Overflow: give the bank back and swallow the rest
                            bank_st[cur] <= B_FREE;
                            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                            wstate <= frame_done ? W_IDLE : W_DROP;
                        end else begin
                            if (wr_valid) begin
                                ram_we    <= 1'b1;
                                ram_waddr <= {cur, wcnt[ADDR_W-1:0]};
                                ram_wdata <= wr_data;
                                wcnt      <= wcnt + 1'b1;
                            end
                            if (frame_done) begin
                                if (commit_len != '0) begin
                                    bank_st[cur] <= B_FULL;
                                    len[cur]     <= commit_len;
                                    older        <= (bank_st[~cur] == B_FULL) ? ~cur : cur;
                                end else begin
                                    bank_st[cur] <= B_FREE;
                                end
                                wstate <= W_IDLE;
                            end
                        end
                    end
                    W_DROP: if (frame_done) wstate <= W_IDLE;
                    default: ;
                endcase
            end
        end
    end

endmodule
